// File: rtl/shr_pkg.sv
// Shared definitions for the shr-bus PSRAM controller: bus widths, FSM
// state encodings and CE# low-time cap. Page-mode states exist only when
// SHR_PSRAM_PAGE_EN is defined.
package shr_pkg;

    localparam int unsigned SHR_ADR_W   = 23;
    localparam int unsigned SHR_DAT_W   = 16;

    // Nexys2 system clock; CE# may stay low for at most 4 us.
    localparam int unsigned SYS_CLK_MHZ   = 50;
    localparam int unsigned CE_MAX_CLOCKS = 4 * SYS_CLK_MHZ;
    localparam int unsigned CE_CAP_W      = $clog2(CE_MAX_CLOCKS + 1);

    // Access / recovery / page wait counter width (values up to 15).
    localparam int unsigned WAIT_CTR_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_WHOLD = 3'd3,
        ST_ACK   = 3'd4,
        ST_RECOV = 3'd5
`ifdef SHR_PSRAM_PAGE_EN
        ,
        ST_PAGE  = 3'd6,
        ST_PRD   = 3'd7
`endif
    } shr_state_t;

endpackage

// File: rtl/shr_wait_ctr.sv
// Loadable down-counter with a zero flag; stops at zero.
// Used for access wait, recovery and CE# low-time cap timing.
module shr_wait_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority over decrement; decrement saturates at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/shr_psram_ctl.sv
// shr-bus slave that turns each strobed cycle into one asynchronous
// access to the Nexys2 cellular RAM and acks once RAM timing is met.
// Optional page-mode reads are enabled by defining SHR_PSRAM_PAGE_EN.
module shr_psram_ctl
    import shr_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES    = 4,
    parameter int unsigned RECOVER_CYCLES = 1,
    parameter int unsigned PAGE_WAIT      = 2
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_res_i,
    input  logic [SHR_ADR_W-1:0] shr_adr_i,
    input  logic [SHR_DAT_W-1:0] shr_dat_i,
    output logic [SHR_DAT_W-1:0] shr_dat_o,
    input  logic [1:0]           shr_sel_i,
    input  logic                 shr_we_i,
    input  logic                 shr_cyc_i,
    input  logic                 shr_stb_i,
    output logic                 shr_ack_o,
    output logic [SHR_ADR_W-1:0] ram_adr_o,
    input  logic [SHR_DAT_W-1:0] ram_dq_i,
    output logic [SHR_DAT_W-1:0] ram_dq_o,
    output logic                 ram_dq_oe,
    output logic                 ram_ce_n,
    output logic                 ram_oe_n,
    output logic                 ram_we_n,
    output logic                 ram_ub_n,
    output logic                 ram_lb_n,
    output logic                 ram_adv_n,
    output logic                 ram_clk,
    output logic                 ram_cre
);

    generate
        if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15) ||
            (RECOVER_CYCLES < 1) || (RECOVER_CYCLES > 3) ||
            (PAGE_WAIT < 1) || (PAGE_WAIT > 15)) begin : g_bad_param
            $error("shr_psram_ctl: timing parameter out of range");
        end
    endgenerate

    localparam logic [WAIT_CTR_W-1:0] WAIT_LD  = WAIT_CTR_W'(WAIT_CYCLES - 1);
    localparam logic [WAIT_CTR_W-1:0] RECOV_LD = WAIT_CTR_W'(RECOVER_CYCLES - 1);

    shr_state_t           r_state;
    logic [SHR_ADR_W-1:0] r_adr;
    logic [SHR_DAT_W-1:0] r_dat;
    logic [SHR_DAT_W-1:0] r_dq_o;
    logic                 r_dq_oe;
    logic                 r_ack;
    logic                 r_ce_n;
    logic                 r_oe_n;
    logic                 r_we_n;
    logic                 r_ub_n;
    logic                 r_lb_n;

    logic                  w_req;
    logic                  w_ld;
    logic [WAIT_CTR_W-1:0] w_ld_val;
    logic                  w_dec;
    logic                  w_zero;

    assign w_req = shr_cyc_i & shr_stb_i;

`ifdef SHR_PSRAM_PAGE_EN
    localparam logic [WAIT_CTR_W-1:0] PAGE_LD = WAIT_CTR_W'(PAGE_WAIT - 1);
    // Cap reload leaves room for one more page read before the 4 us limit.
    localparam logic [CE_CAP_W-1:0]   CAP_LD  = CE_CAP_W'(CE_MAX_CLOCKS - PAGE_WAIT - 1);

    logic r_is_rd;
    logic w_cap_zero;
    logic w_page_hit;
    logic w_page_close;

    // The ack cycle's stb belongs to the transfer just completed, so it is ignored.
    assign w_page_hit   = ~r_ack & w_req & ~shr_we_i & ~w_cap_zero &
                          (shr_adr_i[SHR_ADR_W-1:4] == r_adr[SHR_ADR_W-1:4]);
    assign w_page_close = ~w_page_hit &
                          (~shr_cyc_i | (w_req & ~r_ack) | w_cap_zero);

    shr_wait_ctr #(.W(CE_CAP_W)) u_ce_cap (
        .i_clk  (sys_clk_i),
        .i_rst  (sys_res_i),
        .i_load (r_state == ST_IDLE && w_req),
        .i_val  (CAP_LD),
        .i_dec  (~r_ce_n),
        .o_zero (w_cap_zero)
    );
`endif

    // Counter load/decrement requests for the current state.
    always_comb begin
        w_ld     = 1'b0;
        w_ld_val = '0;
        w_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_ld     = 1'b1;
                    w_ld_val = WAIT_LD;
                end
            end
            ST_RD, ST_WR, ST_RECOV: w_dec = 1'b1;
            ST_ACK: begin
                w_ld     = 1'b1;
                w_ld_val = RECOV_LD;
            end
`ifdef SHR_PSRAM_PAGE_EN
            ST_PAGE: begin
                if (w_page_hit) begin
                    w_ld     = 1'b1;
                    w_ld_val = PAGE_LD;
                end else if (w_page_close) begin
                    w_ld     = 1'b1;
                    w_ld_val = RECOV_LD;
                end
            end
            ST_PRD: w_dec = 1'b1;
`endif
            default: ;
        endcase
    end

    shr_wait_ctr #(.W(WAIT_CTR_W)) u_wait (
        .i_clk  (sys_clk_i),
        .i_rst  (sys_res_i),
        .i_load (w_ld),
        .i_val  (w_ld_val),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    // Access sequencer: drives all RAM strobes and the bus ack from registers.
    always_ff @(posedge sys_clk_i) begin
        if (sys_res_i) begin
            r_state <= ST_IDLE;
            r_adr   <= '0;
            r_dat   <= '0;
            r_dq_o  <= '0;
            r_dq_oe <= 1'b0;
            r_ack   <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
`ifdef SHR_PSRAM_PAGE_EN
            r_is_rd <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_adr  <= shr_adr_i;
                        r_ub_n <= ~shr_sel_i[1];
                        r_lb_n <= ~shr_sel_i[0];
                        r_dq_o <= shr_dat_i;
                        r_ce_n <= 1'b0;
`ifdef SHR_PSRAM_PAGE_EN
                        r_is_rd <= ~shr_we_i;
`endif
                        if (shr_we_i) begin
                            r_we_n  <= 1'b0;
                            r_dq_oe <= 1'b1;
                            r_state <= ST_WR;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (w_zero) begin
                        r_dat   <= ram_dq_i;
`ifndef SHR_PSRAM_PAGE_EN
                        r_oe_n  <= 1'b1;
                        r_ce_n  <= 1'b1;
`endif
                        r_state <= ST_ACK;
                    end
                end
                ST_WR: begin
                    if (w_zero) begin
                        r_we_n  <= 1'b1;
                        r_state <= ST_WHOLD;
                    end
                end
                ST_WHOLD: begin
                    r_dq_oe <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack   <= 1'b1;
`ifdef SHR_PSRAM_PAGE_EN
                    r_state <= r_is_rd ? ST_PAGE : ST_RECOV;
`else
                    r_state <= ST_RECOV;
`endif
                end
                ST_RECOV: begin
                    if (w_zero) begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef SHR_PSRAM_PAGE_EN
                ST_PAGE: begin
                    if (w_page_hit) begin
                        r_adr[3:0] <= shr_adr_i[3:0];
                        r_state    <= ST_PRD;
                    end else if (w_page_close) begin
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_state <= ST_RECOV;
                    end
                end
                ST_PRD: begin
                    if (w_zero) begin
                        r_dat   <= ram_dq_i;
                        r_ack   <= 1'b1;
                        r_state <= ST_PAGE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign shr_dat_o = r_dat;
    assign shr_ack_o = r_ack;
    assign ram_adr_o = r_adr;
    assign ram_dq_o  = r_dq_o;
    assign ram_dq_oe = r_dq_oe;
    assign ram_ce_n  = r_ce_n;
    assign ram_oe_n  = r_oe_n;
    assign ram_we_n  = r_we_n;
    assign ram_ub_n  = r_ub_n;
    assign ram_lb_n  = r_lb_n;
    assign ram_adv_n = 1'b0;
    assign ram_clk   = 1'b0;
    assign ram_cre   = 1'b0;

endmodule
